irq_controller: RTL and testbench

Interrupt controller that drives the single `interrupt` input of the 16-bit processor core (`MP_main`) and is the requesting end of its interrupt handshake. It captures rising edges on up to 8 peripheral request lines, applies a software mask, picks the highest-priority pending source, and presents a request plus vector to the core. It then tracks the core's acknowledge and return-from-interrupt. It sits between peripherals and the core on the core clock, with a small register port for mask/pending access.

---
 rtl/irq_pkg.sv | 24 ++
 rtl/irq_controller_prio_enc.sv | 33 +++
 rtl/irq_controller.sv | 191 +++++++++++++++++++
 tb/tb_irq_controller.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : irq_pkg
// Description : Shared definitions for the interrupt controller: FSM state
//               encoding, register-port address map and the ACTIVE register
//               valid-bit position.
// Revision    : 1.0 - initial release
// ============================================================================
package irq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

    localparam logic [1:0] ADDR_MASK    = 2'd0;
    localparam logic [1:0] ADDR_PENDING = 2'd1;
    localparam logic [1:0] ADDR_ACTIVE  = 2'd2;

    localparam int ACTIVE_VALID_BIT = 15;

endpackage
`default_nettype wire

// File: rtl/irq_controller_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : irq_prio_enc
// Description : Combinational priority encoder. Returns the index of the
//               lowest set bit of req_i (lowest index has highest priority)
//               and a flag telling whether any bit is set.
// Ports       : req_i  - NUM_SRC request vector (pending & mask)
//               id_o   - winning source index (0 when nothing requested)
//               any_o  - at least one request bit set
// Revision    : 1.0 - initial release
// ============================================================================
module irq_prio_enc #(
    parameter int NUM_SRC = 8
) (
    input  logic [NUM_SRC-1:0] req_i,
    output logic [3:0]         id_o,
    output logic               any_o
);

    // Scan from the top down so the last hit (lowest index) wins.
    always_comb begin
        id_o = 4'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                id_o = 4'(i);
            end
        end
    end

    assign any_o = |req_i;

endmodule
`default_nettype wire

// File: rtl/irq_controller.sv
`default_nettype none
// ============================================================================
// Module      : irq_controller
// Description : Edge-triggered interrupt controller for the MP_main core.
//               Captures rising edges on NUM_SRC request lines, masks them,
//               presents the highest-priority source to the core as a
//               registered request plus vector, and follows the core's
//               ack / done handshake (no nesting).
// Ports       : clk, reset (async, active-low)
//               irq_in      - peripheral request lines
//               interrupt   - request to core (registered)
//               int_vector  - vector of presented/active source (registered)
//               int_ack     - core took the request (1-cycle pulse)
//               int_done    - handler returned (1-cycle pulse)
//               cfg_*       - register port: 0 MASK, 1 PENDING (W1C),
//                             2 ACTIVE {valid@15, id@3:0}; read data is
//                             registered, one cycle after cfg_re
// Revision    : 1.0 - initial release
// ============================================================================
module irq_controller
    import irq_pkg::*;
#(
    parameter int          NUM_SRC  = 8,
    parameter logic [15:0] VEC_BASE = 16'h00F0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_in,
    output logic               interrupt,
    output logic [15:0]        int_vector,
    input  logic               int_ack,
    input  logic               int_done,
    input  logic               cfg_we,
    input  logic               cfg_re,
    input  logic [1:0]         cfg_addr,
    input  logic [15:0]        cfg_wdata,
    output logic [15:0]        cfg_rdata
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    irq_state_e         state_q, state_d;
    logic [NUM_SRC-1:0] irq_q;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [3:0]         id_q, id_d;
    logic               act_valid_q, act_valid_d;
    logic               irq_out_q, irq_out_d;
    logic [15:0]        vec_q, vec_d;
    logic [15:0]        rdata_q, rdata_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] w1c;
    logic [NUM_SRC-1:0] ack_clr;
    logic [NUM_SRC-1:0] id_oh;
    logic [3:0]         win_id;
    logic               win_any;
    logic               wr_mask;
    logic               wr_pend;
    logic [15:0]        active_word;
    logic               unused_wdata;

    assign rise    = irq_in & ~irq_q;
    assign wr_mask = cfg_we && (cfg_addr == ADDR_MASK);
    assign wr_pend = cfg_we && (cfg_addr == ADDR_PENDING);
    assign w1c     = wr_pend ? cfg_wdata[NUM_SRC-1:0] : '0;
    assign mask_d  = wr_mask ? cfg_wdata[NUM_SRC-1:0] : mask_q;
    assign id_oh   = NUM_SRC'(1) << id_q;

    // Upper write-data bits are intentionally ignored for small NUM_SRC.
    assign unused_wdata = ^cfg_wdata;

    irq_prio_enc #(
        .NUM_SRC (NUM_SRC)
    ) u_prio_enc (
        .req_i   (pend_q & mask_q),
        .id_o    (win_id),
        .any_o   (win_any)
    );

    // ------------------------------------------------------------------
    // FSM next-state and register updates
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        irq_out_d   = irq_out_q;
        vec_d       = vec_q;
        act_valid_d = act_valid_q;
        ack_clr     = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (win_any) begin
                    id_d      = win_id;
                    vec_d     = VEC_BASE + {12'd0, win_id};
                    irq_out_d = 1'b1;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                if (int_ack) begin
                    ack_clr     = id_oh;
                    irq_out_d   = 1'b0;
                    act_valid_d = 1'b1;
                    state_d     = ST_SERVICE;
                end else if ((|(id_oh & ~mask_d)) || (|(id_oh & w1c))) begin
                    // Software withdrew the presented source (mask cleared or
                    // pending bit cleared) before the core took it.
                    irq_out_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (int_done) begin
                    act_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                irq_out_d   = 1'b0;
                act_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase

        // A fresh edge beats a same-cycle clear (W1C or ack).
        pend_d = (pend_q & ~(w1c | ack_clr)) | rise;
    end

    // ------------------------------------------------------------------
    // Register port read mux
    // ------------------------------------------------------------------
    always_comb begin
        active_word = 16'h0000;
        if (act_valid_q) begin
            active_word[ACTIVE_VALID_BIT] = 1'b1;
            active_word[3:0]              = id_q;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (cfg_re) begin
            rdata_d = 16'h0000;
            unique case (cfg_addr)
                ADDR_MASK:    rdata_d[NUM_SRC-1:0] = mask_q;
                ADDR_PENDING: rdata_d[NUM_SRC-1:0] = pend_q;
                ADDR_ACTIVE:  rdata_d              = active_word;
                default:      rdata_d              = 16'h0000;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            irq_q       <= '0;
            pend_q      <= '0;
            mask_q      <= '0;
            id_q        <= 4'd0;
            act_valid_q <= 1'b0;
            irq_out_q   <= 1'b0;
            vec_q       <= VEC_BASE;
            rdata_q     <= 16'h0000;
        end else begin
            state_q     <= state_d;
            irq_q       <= irq_in;
            pend_q      <= pend_d;
            mask_q      <= mask_d;
            id_q        <= id_d;
            act_valid_q <= act_valid_d;
            irq_out_q   <= irq_out_d;
            vec_q       <= vec_d;
            rdata_q     <= rdata_d;
        end
    end

    assign interrupt  = irq_out_q;
    assign int_vector = vec_q;
    assign cfg_rdata  = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_controller
// Description : Directed self-checking bench for irq_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_controller;

    localparam int          NUM_SRC  = 8;
    localparam logic [15:0] VEC_BASE = 16'h00F0;

    logic               clk;
    logic               reset;
    logic [NUM_SRC-1:0] irq_in;
    logic               interrupt;
    logic [15:0]        int_vector;
    logic               int_ack;
    logic               int_done;
    logic               cfg_we;
    logic               cfg_re;
    logic [1:0]         cfg_addr;
    logic [15:0]        cfg_wdata;
    logic [15:0]        cfg_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    irq_controller #(
        .NUM_SRC  (NUM_SRC),
        .VEC_BASE (VEC_BASE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .interrupt  (interrupt),
        .int_vector (int_vector),
        .int_ack    (int_ack),
        .int_done   (int_done),
        .cfg_we     (cfg_we),
        .cfg_re     (cfg_re),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_rdata  (cfg_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [15:0] data);
        cfg_we    = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = data;
        tick();
        cfg_we    = 1'b0;
        cfg_wdata = 16'h0000;
    endtask

    task automatic cfg_read(input logic [1:0] addr, output logic [15:0] data);
        cfg_re   = 1'b1;
        cfg_addr = addr;
        tick();
        cfg_re   = 1'b0;
        data     = cfg_rdata;
    endtask

    task automatic pulse_ack();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    task automatic pulse_done();
        int_done = 1'b1;
        tick();
        int_done = 1'b0;
    endtask

    // One-cycle request pulse; pending is set at the edge that samples it.
    task automatic pulse_irq(input logic [NUM_SRC-1:0] v);
        irq_in = v;
        tick();
        irq_in = '0;
    endtask

    logic [15:0] rd;

    initial begin
        reset     = 1'b0;
        irq_in    = '0;
        int_ack   = 1'b0;
        int_done  = 1'b0;
        cfg_we    = 1'b0;
        cfg_re    = 1'b0;
        cfg_addr  = 2'd0;
        cfg_wdata = 16'h0000;

        // ---------------- Reset state ----------------
        tick();
        tick();
        check("rst_interrupt", {15'd0, interrupt}, 16'h0000);
        check("rst_vector", int_vector, 16'h00F0);
        check("rst_rdata", cfg_rdata, 16'h0000);
        reset = 1'b1;
        tick();
        cfg_read(2'd0, rd); check("rst_mask", rd, 16'h0000);
        cfg_read(2'd1, rd); check("rst_pending", rd, 16'h0000);
        cfg_read(2'd2, rd); check("rst_active", rd, 16'h0000);

        // ---------------- Single source 0 ----------------
        cfg_write(2'd0, 16'h0001);
        pulse_irq(8'h01);
        check("s0_latency_low", {15'd0, interrupt}, 16'h0000);
        tick();
        check("s0_interrupt", {15'd0, interrupt}, 16'h0001);
        check("s0_vector", int_vector, 16'h00F0);
        pulse_ack();
        check("s0_ack_drop", {15'd0, interrupt}, 16'h0000);
        cfg_read(2'd2, rd); check("s0_active", rd, 16'h8000);
        cfg_read(2'd1, rd); check("s0_pend_cleared", rd, 16'h0000);
        check("s0_vec_service", int_vector, 16'h00F0);
        pulse_done();
        cfg_read(2'd2, rd); check("s0_active_done", rd, 16'h0000);

        // ---------------- Priority: sources 5 and 2 together ----------------
        cfg_write(2'd0, 16'h00FF);
        pulse_irq(8'h24);
        tick();
        check("p_interrupt", {15'd0, interrupt}, 16'h0001);
        check("p_vector_first", int_vector, 16'h00F2);
        pulse_ack();
        pulse_done();
        check("p_gap_after_done", {15'd0, interrupt}, 16'h0000);
        tick();
        check("p_interrupt2", {15'd0, interrupt}, 16'h0001);
        check("p_vector_second", int_vector, 16'h00F5);
        pulse_ack();
        pulse_done();

        // ---------------- No nesting: source 1 during service of 3 ----------------
        pulse_irq(8'h08);
        tick();
        check("n_vector3", int_vector, 16'h00F3);
        pulse_ack();
        pulse_irq(8'h02);
        tick();
        tick();
        check("n_no_preempt", {15'd0, interrupt}, 16'h0000);
        check("n_vec_stable", int_vector, 16'h00F3);
        cfg_read(2'd1, rd); check("n_pending1", rd, 16'h0002);
        cfg_read(2'd2, rd); check("n_active3", rd, 16'h8003);
        pulse_done();
        check("n_gap", {15'd0, interrupt}, 16'h0000);
        tick();
        check("n_interrupt1", {15'd0, interrupt}, 16'h0001);
        check("n_vector1", int_vector, 16'h00F1);
        pulse_ack();
        pulse_done();

        // ---------------- Withdrawal by mask clear ----------------
        pulse_irq(8'h10);
        tick();
        check("w_interrupt4", {15'd0, interrupt}, 16'h0001);
        check("w_vector4", int_vector, 16'h00F4);
        cfg_write(2'd0, 16'h0000);
        tick();
        check("w_dropped", {15'd0, interrupt}, 16'h0000);
        cfg_read(2'd1, rd); check("w_pending_kept", rd, 16'h0010);

        // ---------------- W1C, and set-beats-clear ----------------
        cfg_write(2'd1, 16'h0010);
        cfg_read(2'd1, rd); check("c_w1c", rd, 16'h0000);
        pulse_irq(8'h04);
        cfg_read(2'd1, rd); check("c_pend2", rd, 16'h0004);
        irq_in    = 8'h04;
        cfg_we    = 1'b1;
        cfg_addr  = 2'd1;
        cfg_wdata = 16'h0004;
        tick();
        cfg_we    = 1'b0;
        cfg_wdata = 16'h0000;
        irq_in    = '0;
        cfg_read(2'd1, rd); check("c_set_wins", rd, 16'h0004);
        check("c_masked_quiet", {15'd0, interrupt}, 16'h0000);

        // ---------------- Async reset mid-service ----------------
        cfg_write(2'd0, 16'h0004);
        tick();
        check("r_interrupt2", {15'd0, interrupt}, 16'h0001);
        check("r_vector2", int_vector, 16'h00F2);
        pulse_ack();
        cfg_read(2'd2, rd); check("r_active_pre", rd, 16'h8002);
        reset = 1'b0;
        #2;
        check("r_async_interrupt", {15'd0, interrupt}, 16'h0000);
        check("r_async_vector", int_vector, 16'h00F0);
        check("r_async_rdata", cfg_rdata, 16'h0000);
        reset = 1'b1;
        tick();
        cfg_read(2'd1, rd); check("r_pending", rd, 16'h0000);
        cfg_read(2'd0, rd); check("r_mask", rd, 16'h0000);
        cfg_read(2'd2, rd); check("r_active", rd, 16'h0000);

        // ---------------- Level high at reset release counts as edge ----------------
        reset  = 1'b0;
        irq_in = 8'h01;
        #2;
        reset  = 1'b1;
        cfg_write(2'd0, 16'h0001);
        tick();
        check("l_interrupt", {15'd0, interrupt}, 16'h0001);
        check("l_vector", int_vector, 16'h00F0);
        irq_in = '0;

        // ---------------- Invalid address ----------------
        cfg_read(2'd0, rd); check("i_mask_rd", rd, 16'h0001);
        cfg_write(2'd3, 16'hFFFF);
        cfg_read(2'd3, rd); check("i_invalid_rd", rd, 16'h0000);
        cfg_read(2'd0, rd); check("i_mask_untouched", rd, 16'h0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
